// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the memory stage and the responder.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// Word-wide RAM, per-byte write enable, registered read port; read data holds until the next read.
// One access per edge, no reset, no backpressure.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  input  logic [ADDR_W-1:0]       idx_i,
  input  logic [8*WORD_BYTES-1:0] wdata_i,
  output logic [8*WORD_BYTES-1:0] rdata_o
);

  logic [8*WORD_BYTES-1:0] mem_q [DEPTH_WORDS];
  logic [8*WORD_BYTES-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder: accept, WAIT_CYCLES wait states, one access edge, then a held response.
// Request-to-response latency WAIT_CYCLES+1; rsp_ready low stretches the response and blocks new requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  output logic             busy
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  dmem_state_t             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    we_q;
  logic                    err_q;
  logic [WORD_BYTES-1:0]   be_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [31:0]             wdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic                    rsp_ld_q;

  logic                    accept;
  logic                    req_err;
  logic                    acc_fire;
  logic                    acc_we;
  logic                    acc_err;
  logic [WORD_BYTES-1:0]   acc_be;
  logic [ADDR_W-1:0]       acc_idx;
  logic [31:0]             acc_wdata;
  logic [31:0]             ram_rdata;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_err       = (bus.req_addr[1:0] != 2'b00) || (|(bus.req_addr[31:2] >> ADDR_W));

  // With no wait states the access shares the acceptance edge, so it uses the live request fields.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_fire  = accept;
      acc_we    = bus.req_we;
      acc_err   = req_err;
      acc_be    = bus.req_be;
      acc_idx   = bus.req_addr[ADDR_W+1:2];
      acc_wdata = bus.req_wdata;
    end else begin
      acc_fire  = !rst && (state_q == WAIT) && (cnt_q == '0);
      acc_we    = we_q;
      acc_err   = err_q;
      acc_be    = be_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_ld_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            be_q    <= bus.req_be;
            idx_q   <= bus.req_addr[ADDR_W+1:2];
            wdata_q <= bus.req_wdata;
            err_q   <= req_err;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (acc_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        rsp_ld_q    <= !acc_we && !acc_err;
      end else if ((state_q == RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rsp_ld_q    <= 1'b0;
      end
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (acc_fire && acc_we && !acc_err),
    .re_i    (acc_fire && !acc_we && !acc_err),
    .be_i    (acc_be),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is unreset, so the load data is gated until a good load has completed.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_ld_q ? ram_rdata : 32'h0;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: the slave end of the load/store interface that the datapath drives from its memory stage (ALU result as address, store data as write data, load data returned to writeback). It accepts one word-aligned request at a time through a valid/ready handshake, inserts a configurable number of wait states, and commits the write or returns the read data through a second valid/ready handshake. Its busy indication feeds the hazard logic as a memory-stage stall source.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, at least 2.
- `WAIT_CYCLES`, default 2: wait states between request acceptance and the memory access; legal range 0–15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_be`  in  4  byte-lane enables for stores; bit i selects bits [8i+7:8i].
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  request was misaligned or out of range.
- `busy`  out  1  a request is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid` and `req_ready` are both high, capture address, write data, `req_we` and `req_be`. Go to WAIT if `WAIT_CYCLES`>0, otherwise go directly to RESP.
- WAIT: a down-counter is loaded with `WAIT_CYCLES`-1 on acceptance. On the edge where the counter reaches 0, perform the access and enter RESP.
- The access happens on exactly one edge:
  - Store: write the enabled lanes only. `req_be`=0 is a legal no-op.
  - Load: register the full word, ignoring `req_be`.
- Error check: `addr[1:0]`≠0, or `addr[31:2]` ≥ `DEPTH_WORDS`. On error there is no write, `rsp_rdata`=0 and `rsp_err`=1, with the same latency as a good request.
- RESP: `rsp_valid`=1 and `rsp_rdata`/`rsp_err` held stable until `rsp_valid` and `rsp_ready` are both high. Then return to IDLE.
- `req_ready`=0 in WAIT and RESP. Requests are never pipelined or overlapped.
- A load from a word returns the most recent committed store to that word, including a store whose response is still being held.
- Memory contents are not reset and are X until written.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, counter 0. `req_ready` is forced to 0 during any cycle in which `rst` is high.
- Acceptance at cycle t:
  - `busy`=1 from t+1.
  - Memory write or read occurs at the edge ending cycle t+`WAIT_CYCLES`.
  - `rsp_valid` rises at t+1+`WAIT_CYCLES`.
- With `rsp_ready` held high, the response completes in its first cycle. `req_ready` returns at t+2+`WAIT_CYCLES`, so the minimum request-to-request spacing is `WAIT_CYCLES`+2 cycles.
- `rsp_ready` low stretches RESP indefinitely; outputs must not change while stretched.
- `rsp_ready` high while `rsp_valid` is low has no effect.
- Reset while in WAIT drops the pending store (no write). Reset while in RESP discards the response; a store already committed stays in memory.
- Request fields are sampled only in the acceptance cycle; later changes to them are ignored.

## Structure
- Package `dmem_pkg` holds:
  - the `dmem_state_t` enum (IDLE, WAIT, RESP);
  - `WORD_BYTES`=4;
  - the width of the wait counter (4 bits).
- One sub-module, `dmem_ram`: a `DEPTH_WORDS`×32 array with a per-byte write enable and a registered read port, single clock, no reset. The FSM, capture registers, error check and response registers live in `dmem_responder`.

## Test plan
- Default parameters. Store 0xDEADBEEF to 0x40 with be=0xF, then load 0x40 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; `rsp_valid` rises exactly 3 cycles after each acceptance.
- Store 0x11223344 to 0x80 (be=0xF), then store 0xAABBCCDD with be=0x5, then load 0x80 → 0x11BB33DD.
- Load 0x42 (misaligned) and load 0x1000 (word index 1024, out of range) → both `rsp_err`=1, `rsp_rdata`=0; a load of 0x40 afterwards still returns 0xDEADBEEF.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` and `busy` are stable and `req_ready`=0 throughout; with `req_valid` held high, the next request is accepted only in the cycle after the response handshake.
- Assert `rst` one cycle into WAIT of a store of 0x12345678 to 0x20 (the word previously written as 0x0) → all outputs at reset values; a later load of 0x20 returns 0x0.
- `WAIT_CYCLES`=0: accept at t, `rsp_valid` at t+1; back-to-back loads with `rsp_ready`=1 are accepted every 2 cycles.
